// File: rtl/sqrt_result_collector.sv
// sqrt_result_collector
// Captures each completed square-root result ({N,Sqrt}) on the Done handshake
// into a DEPTH-entry buffer. Provides a registered read port and occupancy,
// Full, Ack and sticky Overflow status.
// Build macro SQRT_CHECK_EN: when defined, a checker flags results that are not
// floor(sqrt(N)) on Err/ErrCount. When undefined, both outputs are tied low.
module sqrt_result_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int NW    = 8,
    parameter int SW    = 4
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             Done,
    input  logic [NW-1:0]    N,
    input  logic [SW-1:0]    Sqrt,
    input  logic             Clear,
    input  logic [AW-1:0]    RdAddr,
    output logic [NW+SW-1:0] RdData,
    output logic [AW:0]      Count,
    output logic             Full,
    output logic             Ack,
    output logic             Overflow,
    output logic             Err,
    output logic [AW:0]      ErrCount
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WAIT_LOW = 2'd2,
        S_FULL     = 2'd3
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW:0]         count_q, count_d;
    logic [NW+SW-1:0]    hold_q, hold_d;
    logic                ovf_q, ovf_d;
    logic                done_dly_q, done_dly_d;
    logic [NW+SW-1:0]    rd_data_q, rd_data_d;
    logic                mem_we;

    logic [NW+SW-1:0]    mem [DEPTH];

    // Next-state and datapath control for the capture FSM; Clear overrides all.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        ovf_d      = ovf_q;
        done_dly_d = Done;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Done) begin
                    hold_d  = {N, Sqrt};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                wptr_d  = (wptr_q == LAST_PTR) ? '0 : wptr_q + AW'(1);
                count_d = count_q + (AW+1)'(1);
                state_d = (count_d == FULL_CNT) ? S_FULL : S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!Done) begin
                    state_d = S_IDLE;
                end
            end
            S_FULL: begin
                if (Done && !done_dly_q) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A Done level already high during Clear must not be captured later.
        if (Clear) begin
            mem_we  = 1'b0;
            wptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = Done ? S_WAIT_LOW : S_IDLE;
        end
    end

    // Masked read: addresses at or beyond the occupancy return zero.
    always_comb begin
        rd_data_d = ({1'b0, RdAddr} < count_q) ? mem[RdAddr] : '0;
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            ovf_q      <= 1'b0;
            done_dly_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
            done_dly_q <= done_dly_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Result buffer write port.
    // NOTE: the array has no reset; stale contents are hidden by the
    // occupancy mask on the read path, so clearing it would buy nothing.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wptr_q] <= hold_q;
        end
    end

`ifdef SQRT_CHECK_EN
    localparam int PW = 2*SW + 1;

    logic          err_q, err_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic [PW-1:0] sq_ext, n_ext, lo, hi;
    logic          bad;

    // Checks the held result against floor(sqrt(N)) during the write cycle.
    always_comb begin
        sq_ext    = PW'(hold_q[SW-1:0]);
        n_ext     = PW'(hold_q[NW+SW-1:SW]);
        lo        = sq_ext * sq_ext;
        hi        = (sq_ext + PW'(1)) * (sq_ext + PW'(1));
        bad       = !((lo <= n_ext) && (n_ext < hi));
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (Clear) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if ((state_q == S_WRITE) && bad) begin
            err_d = 1'b1;
            if (err_cnt_q != FULL_CNT) begin
                err_cnt_d = err_cnt_q + (AW+1)'(1);
            end
        end
    end

    // Sticky error flag and saturating error counter.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Err      = err_q;
    assign ErrCount = err_cnt_q;
`else
    assign Err      = 1'b0;
    assign ErrCount = '0;
`endif

    assign RdData   = rd_data_q;
    assign Count    = count_q;
    assign Full     = (count_q == FULL_CNT);
    assign Ack      = (state_q == S_WRITE) && !Clear;
    assign Overflow = ovf_q;

endmodule
